uart_tx_fifo: RTL
=================

Name: uart_tx_fifo

Overview:
Parametrised UART transmitter with a built-in TX FIFO. It supports configurable data bits, parity and stop bits, and transmits back-to-back frames with no idle gap.
Sits between CPU/peripheral-bus write logic and the board UART pin. It replaces single-byte, start-pulse transmit with a valid/ready push interface.

Parameters:
CLK_FREQ, 50_000_000, system clock frequency in Hz
BAUD_RATE, 115200, line rate; BAUD_DIV = CLK_FREQ/BAUD_RATE clocks per bit (integer division, must be >= 2)
DATA_BITS, 8, data bits per frame, legal 5..8
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, legal 1 or 2
FIFO_DEPTH, 16, FIFO entries, power of two, >= 2

Ports:
clk  input  1  system clock
rst_n  input  1  reset
wr_data  input  8  byte to send; bits above DATA_BITS-1 ignored
wr_valid  input  1  push request
wr_ready  output  1  FIFO can accept; equals !fifo_full
tx_pin  output  1  serial line, idle high
tx_busy  output  1  frame in progress (state != IDLE)
fifo_count  output  clog2(FIFO_DEPTH)+1  entries held
fifo_empty  output  1  fifo_count == 0
fifo_full  output  1  fifo_count == FIFO_DEPTH

Behaviour:
- Clock and reset: clock clk; reset rst_n, asynchronous, active-low.
- Reset values:
  - tx_pin = 1, tx_busy = 0.
  - fifo_count = 0, fifo_empty = 1, fifo_full = 0, wr_ready = 1.
  - State = IDLE; pointers and baud counter cleared.
- Reset mid-frame: line returns high immediately (async). FIFO contents are discarded.
- Push:
  - A push occurs on any rising edge with wr_valid && wr_ready.
  - fifo_count increments in the same edge unless a pop also occurs that edge. Simultaneous push and pop leaves the count unchanged.
  - When full, wr_ready = 0 and no write-through bypass exists. wr_valid while full is simply stalled; data is never lost or overwritten.
- Pointers: wrap modulo FIFO_DEPTH.
- Frame engine states: IDLE, START, DATA, PARITY, STOP. tx_pin is registered.
- IDLE:
  - If the FIFO is non-empty: pop the head into the shift register, enter START, reset the baud counter.
  - tx_pin goes low on the same edge.
  - A byte pushed at edge N into an empty idle block produces tx_pin = 0 from edge N+1.
- Bit timing: each state bit lasts exactly BAUD_DIV clocks, measured by a counter 0..BAUD_DIV-1. The tick occurs at count BAUD_DIV-1.
- START: 1 bit period of 0, then DATA.
- DATA:
  - DATA_BITS periods, LSB first; shift right on each tick.
  - On the final bit, go to PARITY if PARITY != 0, else STOP.
- PARITY: 1 period.
  - Odd: bit = ~^data[DATA_BITS-1:0].
  - Even: bit = ^data[DATA_BITS-1:0].
- STOP: STOP_BITS periods of 1. On the final tick:
  - If the FIFO is non-empty: pop and go straight to START. tx_pin = 0 on that edge, so there is no idle gap.
  - Otherwise go to IDLE.
- Frame length: (1 + DATA_BITS + (PARITY != 0) + STOP_BITS) * BAUD_DIV clocks.
- tx_busy is high from the START entry edge through the end of the last stop bit. It is continuously high across back-to-back frames.

Optional Feature:
Macro UART_TX_CTS_EN.
- When defined:
  - Adds input cts_n (1 bit, active-low clear-to-send, asynchronous from the pin).
  - cts_n is synchronised with a 2-flop synchroniser.
  - A new frame is popped and started (from IDLE or at STOP end) only if the synchronised cts_n == 0.
  - A frame already started always completes.
  - While blocked, the engine sits in IDLE with tx_pin high.
- When undefined: no cts_n port; frames start whenever the FIFO is non-empty.

Test Plan:
1. Defaults (BAUD_DIV = 434), push 0x55 once -> tx_pin low the cycle after the push. Line sequence is 0,1,0,1,0,1,0,1,0,1, each 434 clocks. tx_busy high for 4340 clocks, then 0; fifo_count back to 0.
2. PARITY=2, DATA_BITS=7, STOP_BITS=2, push 0x83 -> data bits 1,1,0,0,0,0,0 (bit 7 ignored), parity 0, then two stop bits. Frame is 11*434 clocks.
3. FIFO_DEPTH=4, push 6 bytes with wr_valid held high:
   - 4 accepted immediately.
   - The first is popped 1 cycle later, so a 5th is accepted then.
   - wr_ready = 0 while full; the 6th is accepted only after the next STOP-end pop.
   - All 6 bytes appear in order with zero idle cycles between frames; tx_busy never drops.
4. Push and pop on the same edge (push exactly at a STOP-end pop with 2 entries held) -> fifo_count stays 2, no data loss or duplication.
5. Assert rst_n low midway through the data bits with 3 bytes queued -> tx_pin = 1 and tx_busy = 0 immediately. After release, fifo_empty = 1 and nothing is transmitted.
6. UART_TX_CTS_EN defined:
   - cts_n = 1, push 0xA5 -> tx_pin stays high, fifo_count = 1.
   - Drop cts_n -> start bit begins 3 clocks later (2 sync + pop).
   - Raise cts_n mid-frame -> frame completes; the next queued byte is held.

Source files
------------

// File: rtl/uart_tx_fifo_if.sv
// Push-side handshake bundle for uart_tx_fifo.
//   wr_data  : byte offered by the producer
//   wr_valid : producer has a byte this cycle
//   wr_ready : transmitter FIFO can take it
// master = producer (bus write logic), slave = uart_tx_fifo.
interface uart_tx_fifo_if;
   logic [7:0] wr_data;
   logic       wr_valid;
   logic       wr_ready;

   modport master (output wr_data, output wr_valid, input wr_ready);
   modport slave  (input wr_data, input wr_valid, output wr_ready);
endinterface

// File: rtl/uart_tx_fifo.sv
// UART transmitter with TX FIFO. Frames are start + DATA_BITS (LSB first)
// + optional parity + STOP_BITS. Queued frames go out back-to-back.
//
// Ports:
//   clk, rst_n  : system clock, asynchronous active-low reset
//   cts_n       : clear-to-send, active low (only with UART_TX_CTS_EN)
//   wr          : push handshake (uart_tx_fifo_if.slave)
//   tx_pin      : registered serial line, idles high
//   tx_busy     : frame in progress
//   fifo_count  : entries held; fifo_empty / fifo_full flags
//
// Optional feature macro: UART_TX_CTS_EN adds cts_n flow control.
//
// state   | meaning
// --------+----------------------------------------------
// S_IDLE  | line high, waiting for FIFO data (and CTS)
// S_START | start bit (0)
// S_DATA  | data bits, LSB first
// S_PARITY| parity bit (only when PARITY != 0)
// S_STOP  | stop bit(s); may chain straight into S_START
module uart_tx_fifo #(
   parameter int CLK_FREQ   = 50_000_000,
   parameter int BAUD_RATE  = 115200,
   parameter int DATA_BITS  = 8,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                          clk,
   input  logic                          rst_n,
`ifdef UART_TX_CTS_EN
   input  logic                          cts_n,
`endif
   uart_tx_fifo_if.slave                 wr,
   output logic                          tx_pin,
   output logic                          tx_busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          fifo_empty,
   output logic                          fifo_full
);

   localparam int BAUD_DIV = CLK_FREQ / BAUD_RATE;
   localparam int AW       = $clog2(FIFO_DEPTH);
   localparam int CW       = $clog2(BAUD_DIV);
   localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);
   localparam logic [AW:0]   DEPTH_L   = (AW+1)'(FIFO_DEPTH);

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

   logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]        wr_ptr, rd_ptr;
   logic [AW:0]          count;
   logic                 push, pop, can_start;
   logic [DATA_BITS-1:0] head;

   state_t               state, state_nxt;
   logic [CW-1:0]        baud_cnt, cnt_nxt;
   logic [2:0]           bit_cnt, bit_nxt;
   logic [DATA_BITS-1:0] shreg, sh_nxt;
   logic                 par_bit, par_nxt, tx_nxt, tick;

   assign fifo_full   = (count == DEPTH_L);
   assign fifo_empty  = (count == '0);
   assign fifo_count  = count;
   assign wr.wr_ready = !fifo_full;
   assign push        = wr.wr_valid && !fifo_full;
   assign head        = mem[rd_ptr];
   assign tx_busy     = (state != S_IDLE);
   assign tick        = (baud_cnt == '0);

`ifdef UART_TX_CTS_EN
   logic cts_meta, cts_sync;

   // Reset to "not clear" so nothing starts until the pin has been sampled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cts_meta <= 1'b1;
         cts_sync <= 1'b1;
      end else begin
         cts_meta <= cts_n;
         cts_sync <= cts_meta;
      end
   end

   assign can_start = !fifo_empty && !cts_sync;
`else
   assign can_start = !fifo_empty;
`endif

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= wr.wr_data[DATA_BITS-1:0];
   end

   // Pointers wrap naturally since FIFO_DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         baud_cnt <= '0;
         bit_cnt  <= '0;
         shreg    <= '0;
         par_bit  <= 1'b0;
         tx_pin   <= 1'b1;
      end else begin
         state    <= state_nxt;
         baud_cnt <= cnt_nxt;
         bit_cnt  <= bit_nxt;
         shreg    <= sh_nxt;
         par_bit  <= par_nxt;
         tx_pin   <= tx_nxt;
      end
   end

   // baud_cnt counts down from BAUD_LAST; the bit ends on the edge where it is 0.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = tick ? BAUD_LAST : baud_cnt - 1'b1;
      bit_nxt   = bit_cnt;
      sh_nxt    = shreg;
      par_nxt   = par_bit;
      tx_nxt    = tx_pin;
      pop       = 1'b0;

      case (state)
         S_IDLE: begin
            tx_nxt  = 1'b1;
            cnt_nxt = baud_cnt;
            if (can_start) pop = 1'b1;
         end
         S_START: begin
            if (tick) begin
               state_nxt = S_DATA;
               bit_nxt   = '0;
               tx_nxt    = shreg[0];
            end
         end
         S_DATA: begin
            if (tick) begin
               if (bit_cnt == 3'(DATA_BITS - 1)) begin
                  if (PARITY != 0) begin
                     state_nxt = S_PARITY;
                     tx_nxt    = par_bit;
                  end else begin
                     state_nxt = S_STOP;
                     tx_nxt    = 1'b1;
                     bit_nxt   = '0;
                  end
               end else begin
                  bit_nxt = bit_cnt + 1'b1;
                  sh_nxt  = shreg >> 1;
                  tx_nxt  = shreg[1];
               end
            end
         end
         S_PARITY: begin
            if (tick) begin
               state_nxt = S_STOP;
               tx_nxt    = 1'b1;
               bit_nxt   = '0;
            end
         end
         S_STOP: begin
            if (tick) begin
               if (bit_cnt == 3'(STOP_BITS - 1)) begin
                  if (can_start) begin
                     pop = 1'b1;
                  end else begin
                     state_nxt = S_IDLE;
                     tx_nxt    = 1'b1;
                  end
               end else begin
                  bit_nxt = bit_cnt + 1'b1;
               end
            end
         end
         default: begin
            state_nxt = S_IDLE;
            tx_nxt    = 1'b1;
         end
      endcase

      // Popping loads the next frame and drives the start bit on the same edge.
      if (pop) begin
         state_nxt = S_START;
         cnt_nxt   = BAUD_LAST;
         sh_nxt    = head;
         par_nxt   = (PARITY == 1) ? ~^head : ^head;
         tx_nxt    = 1'b0;
      end
   end

endmodule
